udp_payload_upsizer: RTL and testbench
======================================

Name: udp_payload_upsizer

Overview:
- Sits between the UDP header/payload source and the wide UDP output path.
- Accepts one UDP header plus an 8-bit AXI-Stream payload frame.
- Forwards the header and packs payload bytes into M_DATA_WIDTH-bit beats with tkeep.
- Checks the payload byte count against udp_length and flags errors on tuser of the last output beat.

Parameters:
- M_DATA_WIDTH, 64, output payload width in bits; multiple of 8, range 16..512; R = M_DATA_WIDTH/8 bytes per beat.
- KEEP_WIDTH, M_DATA_WIDTH/8, output tkeep width; derived, not overridden.
- LEN_CHECK_EN, 1, 1 = byte-count check drives tuser; 0 = tuser is the OR of input tuser only.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous active-low reset.
- s_udp_hdr_valid / s_udp_hdr_ready  in / out  1/1  input header handshake.
- s_udp_ip_dscp, s_udp_ip_ecn, s_udp_ip_ttl  in  6/2/8  IP fields.
- s_udp_ip_source_ip, s_udp_ip_dest_ip  in  32/32  IP addresses.
- s_udp_source_port, s_udp_dest_port, s_udp_length, s_udp_checksum  in  16 each  UDP fields.
- s_udp_payload_axis_tdata  in  8  payload byte.
- s_udp_payload_axis_tvalid, _tlast, _tuser  in  1 each  payload control.
- s_udp_payload_axis_tready  out  1  payload ready.
- m_udp_hdr_valid / m_udp_hdr_ready  out / in  1/1  output header handshake.
- m_udp_ip_dscp … m_udp_checksum  out  same widths as s_ side  registered copies of the header fields.
- m_udp_payload_axis_tdata  out  M_DATA_WIDTH  packed payload.
- m_udp_payload_axis_tkeep  out  KEEP_WIDTH  byte enables.
- m_udp_payload_axis_tvalid, _tlast, _tuser  out  1 each  output control.
- m_udp_payload_axis_tready  in  1  output ready.

Behaviour:
- Reset (rst=0, asynchronous):
  - State goes to IDLE.
  - All valids, readies, tlast, tuser, tkeep, tdata, header registers, byte counter and fill index clear to 0.
  - A partially packed beat is discarded.
  - s_udp_hdr_ready is registered and rises on the first clk edge after rst deasserts.
- IDLE: s_udp_hdr_ready=1.
  - On hdr valid&ready: latch all header fields, clear byte_cnt (16-bit) and fill index, clear err, then go to HDR.
  - s_udp_hdr_ready drops in the same edge.
- HDR: m_udp_hdr_valid=1 with the latched fields held stable.
  - On m_udp_hdr_ready: go to IDLE if s_udp_length==8, otherwise go to PAYLOAD.
  - The header leaves one cycle after input acceptance at minimum.
- PAYLOAD: s_udp_payload_axis_tready = !m_tvalid || m_tready (output register free or draining).
  - Each accepted byte is written to lane [fill*8 +: 8]; lane 0 is the first byte.
  - On each accepted byte: fill increments, byte_cnt increments (saturates at 0xFFFF), and err |= input tuser.
  - When fill==R-1 or tlast is accepted, load the output register on the same edge:
    - tdata = packed lanes, with unused lanes 0;
    - tkeep = contiguous low bits, one per filled lane;
    - tvalid=1, fill resets to 0.
  - A completed beat is visible the cycle after its final byte is accepted.
- On the beat carrying tlast:
  - m_tlast=1.
  - m_tuser = err OR (LEN_CHECK_EN AND mismatch).
  - mismatch = (s_udp_length<8) OR (byte_cnt_final != s_udp_length-8).
  - Then go to FLUSH.
- Non-last beats have tlast=0 and tuser=0.
- FLUSH: tready=0. When the output beat is accepted (or already gone), go to IDLE.
- Output hold: m_* payload signals are held stable while tvalid=1 and tready=0.
- Length boundaries:
  - udp_length<8: header is still forwarded, payload frame consumed, tuser=1.
  - Frame longer than udp_length-8: entire frame consumed, tuser=1.
- Throughput: one byte per cycle sustained with m_tready=1. Header handling adds 2 idle cycles between frames.
- Reset mid-frame: the partial frame is dropped with no output tlast emitted. The remaining input bytes of that frame are the source's responsibility.

Test Plan:
- udp_length=16, bytes 0x01..0x08, m_tready=1 -> one beat: tdata=0x0807060504030201, tkeep=0xFF, tlast=1, tuser=0.
- udp_length=19, 11 bytes 0x10..0x1A -> beat1: tkeep=0xFF, tlast=0; beat2: tdata=0x00000000001A1918, tkeep=0x07, tlast=1, tuser=0.
- udp_length=20, 10 bytes sent -> last beat tkeep=0x03, tuser=1. Same with LEN_CHECK_EN=0 -> tuser=0.
- udp_length=8 -> m_udp_hdr_valid pulses for one handshake; no payload beats; s_udp_hdr_ready=1 again within 2 cycles.
- 16-byte frame with m_tready held 0 for 5 cycles after the first beat -> s_tready=0 during stall, beat data/tkeep stable, second beat correct once m_tready=1.
- rst pulled low mid-PAYLOAD after 3 bytes -> all valids 0 immediately; after release s_udp_hdr_ready=1 and next frame (udp_length=16) outputs a correct single beat.

Source files
------------

// File: rtl/udp_payload_upsizer.sv
// UDP payload upsizer: forwards one UDP header and packs its 8-bit payload stream
// into M_DATA_WIDTH-bit beats with tkeep; flags length/tuser errors on the last beat.
module udp_payload_upsizer #(
  parameter int unsigned M_DATA_WIDTH = 64,
  parameter int unsigned KEEP_WIDTH   = M_DATA_WIDTH / 8,
  parameter bit          LEN_CHECK_EN = 1'b1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    s_udp_hdr_valid,
  output logic                    s_udp_hdr_ready,
  input  logic [5:0]              s_udp_ip_dscp,
  input  logic [1:0]              s_udp_ip_ecn,
  input  logic [7:0]              s_udp_ip_ttl,
  input  logic [31:0]             s_udp_ip_source_ip,
  input  logic [31:0]             s_udp_ip_dest_ip,
  input  logic [15:0]             s_udp_source_port,
  input  logic [15:0]             s_udp_dest_port,
  input  logic [15:0]             s_udp_length,
  input  logic [15:0]             s_udp_checksum,
  input  logic [7:0]              s_udp_payload_axis_tdata,
  input  logic                    s_udp_payload_axis_tvalid,
  input  logic                    s_udp_payload_axis_tlast,
  input  logic                    s_udp_payload_axis_tuser,
  output logic                    s_udp_payload_axis_tready,
  output logic                    m_udp_hdr_valid,
  input  logic                    m_udp_hdr_ready,
  output logic [5:0]              m_udp_ip_dscp,
  output logic [1:0]              m_udp_ip_ecn,
  output logic [7:0]              m_udp_ip_ttl,
  output logic [31:0]             m_udp_ip_source_ip,
  output logic [31:0]             m_udp_ip_dest_ip,
  output logic [15:0]             m_udp_source_port,
  output logic [15:0]             m_udp_dest_port,
  output logic [15:0]             m_udp_length,
  output logic [15:0]             m_udp_checksum,
  output logic [M_DATA_WIDTH-1:0] m_udp_payload_axis_tdata,
  output logic [KEEP_WIDTH-1:0]   m_udp_payload_axis_tkeep,
  output logic                    m_udp_payload_axis_tvalid,
  output logic                    m_udp_payload_axis_tlast,
  output logic                    m_udp_payload_axis_tuser,
  input  logic                    m_udp_payload_axis_tready
);

  localparam int unsigned R     = KEEP_WIDTH;
  localparam int unsigned FillW = $clog2(R);

  typedef enum logic [1:0] {StIdle, StHdr, StPayload, StFlush} state_e;

  state_e                  state_q, state_d;
  logic                    hdr_ready_q;
  logic [143:0]            hdr_q;
  logic [FillW-1:0]        fill_q, fill_d;
  logic [15:0]             cnt_q, cnt_d;
  logic                    err_q, err_d;
  logic [M_DATA_WIDTH-1:0] lanes_q, lanes_d;
  logic [M_DATA_WIDTH-1:0] tdata_q, tdata_d;
  logic [KEEP_WIDTH-1:0]   tkeep_q, tkeep_d;
  logic                    tvalid_q, tvalid_d;
  logic                    tlast_q, tlast_d;
  logic                    tuser_q, tuser_d;
  logic                    hdr_accept, in_accept, mismatch;

  assign {m_udp_ip_dscp, m_udp_ip_ecn, m_udp_ip_ttl, m_udp_ip_source_ip, m_udp_ip_dest_ip,
          m_udp_source_port, m_udp_dest_port, m_udp_length, m_udp_checksum} = hdr_q;

  assign s_udp_hdr_ready           = hdr_ready_q;
  assign m_udp_hdr_valid           = (state_q == StHdr);
  assign s_udp_payload_axis_tready = (state_q == StPayload) &&
                                     (!tvalid_q || m_udp_payload_axis_tready);
  assign hdr_accept                = s_udp_hdr_valid && hdr_ready_q;
  assign in_accept                 = s_udp_payload_axis_tvalid && s_udp_payload_axis_tready;
  assign m_udp_payload_axis_tdata  = tdata_q;
  assign m_udp_payload_axis_tkeep  = tkeep_q;
  assign m_udp_payload_axis_tvalid = tvalid_q;
  assign m_udp_payload_axis_tlast  = tlast_q;
  assign m_udp_payload_axis_tuser  = tuser_q;

  always_comb begin
    state_d  = state_q;
    fill_d   = fill_q;
    cnt_d    = cnt_q;
    err_d    = err_q;
    lanes_d  = lanes_q;
    tdata_d  = tdata_q;
    tkeep_d  = tkeep_q;
    tvalid_d = tvalid_q && !m_udp_payload_axis_tready;
    tlast_d  = tlast_q;
    tuser_d  = tuser_q;
    mismatch = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (hdr_accept) begin
          state_d = StHdr;
          fill_d  = '0;
          cnt_d   = '0;
          err_d   = 1'b0;
          lanes_d = '0;
        end
      end
      StHdr: begin
        if (m_udp_hdr_ready) state_d = (m_udp_length == 16'd8) ? StIdle : StPayload;
      end
      StPayload: begin
        if (in_accept) begin
          lanes_d[8*fill_q +: 8] = s_udp_payload_axis_tdata;
          cnt_d    = (cnt_q == 16'hFFFF) ? cnt_q : cnt_q + 16'd1;
          err_d    = err_q | s_udp_payload_axis_tuser;
          mismatch = (m_udp_length < 16'd8) || (cnt_d != m_udp_length - 16'd8);
          if (fill_q == FillW'(R - 1) || s_udp_payload_axis_tlast) begin
            // Output register is free here: tready to the source implies it.
            tdata_d  = lanes_d;
            lanes_d  = '0;
            fill_d   = '0;
            tvalid_d = 1'b1;
            for (int unsigned i = 0; i < R; i++) tkeep_d[i] = (FillW'(i) <= fill_q);
            tlast_d  = s_udp_payload_axis_tlast;
            tuser_d  = s_udp_payload_axis_tlast && (err_d || (LEN_CHECK_EN && mismatch));
            if (s_udp_payload_axis_tlast) state_d = StFlush;
          end else begin
            fill_d = fill_q + FillW'(1);
          end
        end
      end
      StFlush: begin
        if (!tvalid_q || m_udp_payload_axis_tready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= StIdle;
      hdr_ready_q <= 1'b0;
      hdr_q       <= '0;
      fill_q      <= '0;
      cnt_q       <= '0;
      err_q       <= 1'b0;
      lanes_q     <= '0;
      tdata_q     <= '0;
      tkeep_q     <= '0;
      tvalid_q    <= 1'b0;
      tlast_q     <= 1'b0;
      tuser_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      hdr_ready_q <= (state_d == StIdle);
      if (hdr_accept) begin
        hdr_q <= {s_udp_ip_dscp, s_udp_ip_ecn, s_udp_ip_ttl, s_udp_ip_source_ip,
                  s_udp_ip_dest_ip, s_udp_source_port, s_udp_dest_port, s_udp_length,
                  s_udp_checksum};
      end
      fill_q      <= fill_d;
      cnt_q       <= cnt_d;
      err_q       <= err_d;
      lanes_q     <= lanes_d;
      tdata_q     <= tdata_d;
      tkeep_q     <= tkeep_d;
      tvalid_q    <= tvalid_d;
      tlast_q     <= tlast_d;
      tuser_q     <= tuser_d;
    end
  end

endmodule

// File: tb/tb_udp_payload_upsizer.sv
// Self-checking bench for udp_payload_upsizer: table-driven frames with a beat/header
// scoreboard, plus hand sequences for udp_length=8, output stall and mid-frame reset.
module tb_udp_payload_upsizer;

  localparam int unsigned W = 64;
  localparam int unsigned R = W / 8;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic         s_hdr_valid, s_hdr_ready, s_hdr_ready0;
  logic [5:0]   s_dscp;
  logic [1:0]   s_ecn;
  logic [7:0]   s_ttl;
  logic [31:0]  s_sip, s_dip;
  logic [15:0]  s_sport, s_dport, s_len, s_csum;
  logic [7:0]   s_tdata;
  logic         s_tvalid, s_tlast, s_tuser, s_tready, s_tready0;
  logic         m_hdr_valid, m_hdr_ready, m_hdr_valid0;
  logic [5:0]   m_dscp, m_dscp0;
  logic [1:0]   m_ecn, m_ecn0;
  logic [7:0]   m_ttl, m_ttl0;
  logic [31:0]  m_sip, m_dip, m_sip0, m_dip0;
  logic [15:0]  m_sport, m_dport, m_len, m_csum, m_sport0, m_dport0, m_len0, m_csum0;
  logic [W-1:0] m_tdata, m_tdata0;
  logic [R-1:0] m_tkeep, m_tkeep0;
  logic         m_tvalid, m_tlast, m_tuser, m_tready;
  logic         m_tvalid0, m_tlast0, m_tuser0;

  udp_payload_upsizer #(.M_DATA_WIDTH(W), .LEN_CHECK_EN(1'b1)) dut (
    .clk(clk), .rst(rst),
    .s_udp_hdr_valid(s_hdr_valid), .s_udp_hdr_ready(s_hdr_ready),
    .s_udp_ip_dscp(s_dscp), .s_udp_ip_ecn(s_ecn), .s_udp_ip_ttl(s_ttl),
    .s_udp_ip_source_ip(s_sip), .s_udp_ip_dest_ip(s_dip),
    .s_udp_source_port(s_sport), .s_udp_dest_port(s_dport),
    .s_udp_length(s_len), .s_udp_checksum(s_csum),
    .s_udp_payload_axis_tdata(s_tdata), .s_udp_payload_axis_tvalid(s_tvalid),
    .s_udp_payload_axis_tlast(s_tlast), .s_udp_payload_axis_tuser(s_tuser),
    .s_udp_payload_axis_tready(s_tready),
    .m_udp_hdr_valid(m_hdr_valid), .m_udp_hdr_ready(m_hdr_ready),
    .m_udp_ip_dscp(m_dscp), .m_udp_ip_ecn(m_ecn), .m_udp_ip_ttl(m_ttl),
    .m_udp_ip_source_ip(m_sip), .m_udp_ip_dest_ip(m_dip),
    .m_udp_source_port(m_sport), .m_udp_dest_port(m_dport),
    .m_udp_length(m_len), .m_udp_checksum(m_csum),
    .m_udp_payload_axis_tdata(m_tdata), .m_udp_payload_axis_tkeep(m_tkeep),
    .m_udp_payload_axis_tvalid(m_tvalid), .m_udp_payload_axis_tlast(m_tlast),
    .m_udp_payload_axis_tuser(m_tuser), .m_udp_payload_axis_tready(m_tready)
  );

  udp_payload_upsizer #(.M_DATA_WIDTH(W), .LEN_CHECK_EN(1'b0)) dut_nochk (
    .clk(clk), .rst(rst),
    .s_udp_hdr_valid(s_hdr_valid), .s_udp_hdr_ready(s_hdr_ready0),
    .s_udp_ip_dscp(s_dscp), .s_udp_ip_ecn(s_ecn), .s_udp_ip_ttl(s_ttl),
    .s_udp_ip_source_ip(s_sip), .s_udp_ip_dest_ip(s_dip),
    .s_udp_source_port(s_sport), .s_udp_dest_port(s_dport),
    .s_udp_length(s_len), .s_udp_checksum(s_csum),
    .s_udp_payload_axis_tdata(s_tdata), .s_udp_payload_axis_tvalid(s_tvalid),
    .s_udp_payload_axis_tlast(s_tlast), .s_udp_payload_axis_tuser(s_tuser),
    .s_udp_payload_axis_tready(s_tready0),
    .m_udp_hdr_valid(m_hdr_valid0), .m_udp_hdr_ready(m_hdr_ready),
    .m_udp_ip_dscp(m_dscp0), .m_udp_ip_ecn(m_ecn0), .m_udp_ip_ttl(m_ttl0),
    .m_udp_ip_source_ip(m_sip0), .m_udp_ip_dest_ip(m_dip0),
    .m_udp_source_port(m_sport0), .m_udp_dest_port(m_dport0),
    .m_udp_length(m_len0), .m_udp_checksum(m_csum0),
    .m_udp_payload_axis_tdata(m_tdata0), .m_udp_payload_axis_tkeep(m_tkeep0),
    .m_udp_payload_axis_tvalid(m_tvalid0), .m_udp_payload_axis_tlast(m_tlast0),
    .m_udp_payload_axis_tuser(m_tuser0), .m_udp_payload_axis_tready(m_tready)
  );

  typedef struct {
    logic [W-1:0] data;
    logic [R-1:0] keep;
    logic         last;
    logic         user;
  } beat_t;

  typedef struct {
    logic [15:0]  len;
    int           n;
    logic [7:0]   base;
    int           user_pos;   // byte index carrying input tuser, -1 for none
    logic [R-1:0] last_keep;
    logic         user_chk;   // expected last-beat tuser with length check on
    logic         user_nochk; // expected last-beat tuser with length check off
  } vec_t;

  beat_t        exp_q[$];
  logic         exp0_q[$];
  logic [143:0] hdr_exp_q[$];
  vec_t         vecs[7];
  int           n_total = 0;
  int           n_pass  = 0;

  task automatic check(input string name, input logic [143:0] act, input logic [143:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  task automatic fail(input string name);
    n_total++;
    $display("FAIL %s: event not observed within bound", name);
  endtask

  function automatic logic [143:0] hdr_of(input logic [15:0] len);
    return {6'h2A, 2'h1, 8'h40, 32'hC0A80000 | {16'h0, len}, 32'h0A000000 | {16'h0, len},
            16'h1000 ^ len, 16'h2000 ^ len, len, ~len};
  endfunction

  always @(negedge clk) begin : monitor
    beat_t        b;
    logic [143:0] h;
    logic         u;
    if (rst) begin
      if (m_hdr_valid && m_hdr_ready) begin
        if (hdr_exp_q.size() == 0) fail("hdr_unexpected");
        else begin
          h = hdr_exp_q.pop_front();
          check("hdr_fields", {m_dscp, m_ecn, m_ttl, m_sip, m_dip, m_sport, m_dport, m_len,
                               m_csum}, h);
        end
      end
      if (m_tvalid && m_tready) begin
        if (exp_q.size() == 0) fail("beat_unexpected");
        else begin
          b = exp_q.pop_front();
          check("beat_tdata", 144'(m_tdata), 144'(b.data));
          check("beat_tkeep", 144'(m_tkeep), 144'(b.keep));
          check("beat_tlast", 144'(m_tlast), 144'(b.last));
          check("beat_tuser", 144'(m_tuser), 144'(b.user));
        end
      end
      if (m_tvalid0 && m_tready && m_tlast0) begin
        if (exp0_q.size() == 0) fail("nochk_unexpected");
        else begin
          u = exp0_q.pop_front();
          check("nochk_tuser", 144'(m_tuser0), 144'(u));
        end
      end
    end
  end

  task automatic send_hdr(input logic [15:0] len);
    int n = 0;
    bit ok = 0;
    {s_dscp, s_ecn, s_ttl, s_sip, s_dip, s_sport, s_dport, s_len, s_csum} = hdr_of(len);
    s_hdr_valid = 1'b1;
    hdr_exp_q.push_back(hdr_of(len));
    while (!ok && n < 200) begin
      @(negedge clk);
      ok = s_hdr_ready;
      @(posedge clk);
      #1;
      n++;
    end
    s_hdr_valid = 1'b0;
    if (!ok) fail("hdr_handshake");
  endtask

  task automatic send_byte(input logic [7:0] d, input logic last, input logic user);
    int n = 0;
    bit ok = 0;
    s_tdata  = d;
    s_tlast  = last;
    s_tuser  = user;
    s_tvalid = 1'b1;
    while (!ok && n < 200) begin
      @(negedge clk);
      ok = s_tready;
      @(posedge clk);
      #1;
      n++;
    end
    s_tvalid = 1'b0;
    s_tlast  = 1'b0;
    s_tuser  = 1'b0;
    if (!ok) fail("byte_handshake");
  endtask

  task automatic send_frame(input vec_t v);
    int    nb;
    beat_t b;
    send_hdr(v.len);
    nb = (v.n + R - 1) / R;
    for (int k = 0; k < nb; k++) begin
      b.data = '0;
      for (int i = 0; i < R; i++) if (k * R + i < v.n) b.data[i*8 +: 8] = v.base + 8'(k * R + i);
      b.last = (k == nb - 1);
      b.keep = b.last ? v.last_keep : {R{1'b1}};
      b.user = b.last ? v.user_chk : 1'b0;
      exp_q.push_back(b);
    end
    exp0_q.push_back(v.user_nochk);
    for (int i = 0; i < v.n; i++) send_byte(v.base + 8'(i), i == v.n - 1, i == v.user_pos);
  endtask

  task automatic drain();
    int n = 0;
    while ((exp_q.size() != 0 || exp0_q.size() != 0 || hdr_exp_q.size() != 0) && n < 500) begin
      @(posedge clk);
      n++;
    end
    if (n >= 500) fail("drain");
    @(posedge clk);
    #1;
  endtask

  initial begin
    bit   ok;
    int   n;
    vec_t v;
    vecs[0] = '{16'd16, 8,  8'h01, -1, 8'hFF, 1'b0, 1'b0};
    vecs[1] = '{16'd19, 11, 8'h10, -1, 8'h07, 1'b0, 1'b0};
    vecs[2] = '{16'd20, 10, 8'h30, -1, 8'h03, 1'b1, 1'b0};
    vecs[3] = '{16'd4,  3,  8'h60, -1, 8'h07, 1'b1, 1'b0};
    vecs[4] = '{16'd12, 6,  8'h70, -1, 8'h3F, 1'b1, 1'b0};
    vecs[5] = '{16'd12, 4,  8'h80, 2,  8'h0F, 1'b1, 1'b1};
    vecs[6] = '{16'd24, 16, 8'h90, -1, 8'hFF, 1'b0, 1'b0};

    s_hdr_valid = 0; s_tvalid = 0; s_tlast = 0; s_tuser = 0; s_tdata = 0;
    {s_dscp, s_ecn, s_ttl, s_sip, s_dip, s_sport, s_dport, s_len, s_csum} = '0;
    m_hdr_ready = 1; m_tready = 1;

    repeat (2) @(posedge clk);
    #1;
    check("rst_hdr_ready", 144'(s_hdr_ready), 0);
    check("rst_m_hdr_valid", 144'(m_hdr_valid), 0);
    check("rst_m_tvalid", 144'(m_tvalid), 0);
    check("rst_m_tdata_tkeep", 144'({m_tdata, m_tkeep}), 0);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("post_rst_hdr_ready", 144'(s_hdr_ready), 1);

    for (int i = 0; i < 7; i++) send_frame(vecs[i]);
    drain();

    // udp_length == 8: header only, ready returns within 2 cycles, no payload beat
    send_hdr(16'd8);
    ok = 0;
    repeat (2) begin
      @(negedge clk);
      if (s_hdr_ready) ok = 1;
    end
    check("len8_hdr_ready_back", 144'(ok), 1);
    repeat (4) @(negedge clk);
    check("len8_no_beat", 144'(m_tvalid), 0);
    check("len8_hdr_consumed", 144'(hdr_exp_q.size()), 0);
    @(posedge clk);
    #1;

    // Output stall: m_tready low for 5 cycles once the first beat is presented
    m_tready = 1'b0;
    v = '{16'd24, 16, 8'h50, -1, 8'hFF, 1'b0, 1'b0};
    fork
      send_frame(v);
      begin
        n = 0;
        while (!m_tvalid && n < 300) begin
          @(negedge clk);
          n++;
        end
        if (!m_tvalid) fail("stall_first_beat");
        repeat (5) begin
          check("stall_s_tready", 144'(s_tready), 0);
          check("stall_tdata", 144'(m_tdata), 144'(64'h5756555453525150));
          check("stall_tkeep", 144'(m_tkeep), 144'(8'hFF));
          @(negedge clk);
        end
        @(posedge clk);
        #1;
        m_tready = 1'b1;
      end
    join
    drain();

    // Reset mid-payload after 3 bytes: partial beat dropped
    send_hdr(16'd16);
    for (int i = 0; i < 3; i++) send_byte(8'hA0 + 8'(i), 1'b0, 1'b0);
    rst = 1'b0;
    #1;
    check("midrst_m_tvalid", 144'(m_tvalid), 0);
    check("midrst_m_hdr_valid", 144'(m_hdr_valid), 0);
    check("midrst_s_ready", 144'({s_hdr_ready, s_tready}), 0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("midrst_hdr_ready", 144'(s_hdr_ready), 1);
    check("midrst_hdr_queue", 144'(hdr_exp_q.size()), 0);
    v = '{16'd16, 8, 8'h41, -1, 8'hFF, 1'b0, 1'b0};
    send_frame(v);
    drain();
    check("final_beats_drained", 144'(exp_q.size()), 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
